// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesting agents and the round-robin arbiter.
// The master side drives requests; the slave side is the arbiter.
interface rr_arbiter8_if;
   logic       enable;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   modport master (
      output enable,
      output req,
      input  gnt,
      input  gnt_idx,
      input  gnt_valid,
      input  timeout
   );

   modport slave (
      input  enable,
      input  req,
      output gnt,
      output gnt_idx,
      output gnt_valid,
      output timeout
   );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a registered one-hot grant and a per-grant hold limit
// that forces rotation when other requesters are waiting.
module rr_arbiter8 #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 5
) (
   input logic          clk,
   input logic          rst,
   rr_arbiter8_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   localparam logic [CNT_W-1:0] HoldLast = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
   localparam logic             LimitOn  = (MAX_HOLD != 0);

   state_e           state_q, state_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [7:0]       gnt_q, gnt_d;
   logic [2:0]       gnt_idx_q, gnt_idx_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

   logic [2:0] pick_idx;
   logic [2:0] cand;
   logic       pick_found;
   logic       compete;
   logic       limit_hit;

   // Scan from ptr+7 down to ptr so the lowest rotating offset wins.
   always_comb begin
      pick_idx   = ptr_q;
      pick_found = 1'b0;
      cand       = ptr_q;
      for (int i = 7; i >= 0; i--) begin
         cand = ptr_q + 3'(i);
         if (bus.req[cand]) begin
            pick_idx   = cand;
            pick_found = 1'b1;
         end
      end
   end

   assign compete   = |(bus.req & ~gnt_q);
   assign limit_hit = LimitOn && (hold_cnt_q == HoldLast);

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;
      hold_cnt_d  = hold_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (bus.enable && pick_found) begin
               state_d     = StGrant;
               gnt_idx_d   = pick_idx;
               gnt_d       = 8'h01 << pick_idx;
               gnt_valid_d = 1'b1;
               hold_cnt_d  = '0;
            end else begin
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
            end
         end
         StGrant: begin
            if (!bus.enable || !bus.req[gnt_idx_q] || (limit_hit && compete)) begin
               state_d     = StIdle;
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
               ptr_d       = gnt_idx_q + 3'd1;
               hold_cnt_d  = '0;
               // Only the hold limit counts as a forced release.
               timeout_d   = bus.enable && bus.req[gnt_idx_q];
            end else if (hold_cnt_q != HoldLast) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d     = StIdle;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         gnt_q       <= '0;
         gnt_idx_q   <= '0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         hold_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = gnt_idx_q;
   assign bus.gnt_valid = gnt_valid_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one 8-way one-hot select resource (the 3-to-8 decoded enable bus) among 8 requesters. It accepts a request vector, grants exactly one requester at a time, and drives both the 3-bit grant index and its registered one-hot decode. A per-grant hold limit forces rotation when other requesters are waiting. It sits between the requesting agents and the shared resource they select.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles while other requests are pending. 0 disables the limit.
- `CNT_W`, default 5: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `enable`, input, 1: arbiter enable. Low forces release and blocks new grants.
- `req`, input, 8: request vector. Bit i is requester i. Level-sensitive, held high for the whole time it wants ownership.
- `gnt`, output, 8: registered one-hot grant. Equals 1<<gnt_idx when gnt_valid, else 0.
- `gnt_idx`, output, 3: index of the current owner. Holds its last value when gnt_valid=0.
- `gnt_valid`, output, 1: a grant is active.
- `timeout`, output, 1: one-cycle pulse on a forced (hold-limit) release.

## Operation
- State machine with two states: IDLE and GRANT. There is also an internal 3-bit priority pointer `ptr`, which is the highest-priority index.
- Reset values: state=IDLE, ptr=0, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, hold_cnt=0.
- **IDLE:**
  - If enable=1 and req≠0: select the first set bit of req, scanning ptr, ptr+1, … ptr+7 (mod 8).
  - Register that index into gnt_idx, set gnt_valid=1 and gnt=1<<index, clear hold_cnt, go to GRANT.
  - Otherwise stay in IDLE with all grant outputs 0.
- **GRANT**, evaluated each cycle in priority order:
  1. enable=0: release.
  2. req[gnt_idx]=0: release (voluntary).
  3. MAX_HOLD≠0, hold_cnt==MAX_HOLD-1, and (req & ~gnt)≠0: forced release, with timeout=1 for that one cycle.
  4. Else: stay in GRANT. hold_cnt increments, saturating at MAX_HOLD-1.
- **Release** (any cause):
  - Next cycle: state=IDLE, gnt=0, gnt_valid=0.
  - ptr = gnt_idx+1 mod 8, so 7 wraps to 0.
  - gnt_idx keeps its value.
- If no other requester is pending when the limit is reached, the owner keeps the grant, the counter stays saturated, and no timeout pulse is issued. If another request appears later while saturated, forced release happens on the next evaluated edge.
- Requests that arrive or drop while another requester owns the grant are ignored until the next IDLE arbitration.
- gnt is always one-hot or all-zero. Two bits are never set simultaneously.

## Timing
- Grant latency: req sampled high in IDLE at edge N produces gnt/gnt_valid high after edge N. That is one cycle.
- Release latency: a release condition sampled at edge N drops gnt after edge N.
- Mandatory one-cycle IDLE bubble between any two grants. Minimum handover from owner A dropping req to owner B's grant is 2 edges.
- Forced-release timing: an owner that starts holding at edge G, with competition pending, has gnt high for exactly MAX_HOLD cycles. timeout is high during the cycle after the edge at which release is decided, coincident with gnt=0.
- All outputs are registered. There are no combinational paths from req/enable to outputs.
- Asynchronous rst mid-grant clears all outputs immediately, independent of clk. Arbitration resumes from ptr=0 on the first edge after rst deasserts.

## Test plan
- Reset/idle: assert rst mid-grant (gnt=8'b0000_0100) → gnt=0, gnt_valid=0, gnt_idx=0 without a clock edge. With req=0 after reset, outputs stay 0.
- Single requester: req=8'b0000_1000 → gnt=8'b0000_1000, gnt_idx=3 one cycle later. Drop req[3] → gnt=0 next cycle, ptr=4.
- Round-robin fairness: req=8'hFF held, with each owner dropping its req after 2 cycles and re-raising it. Grant order is 0,1,2,…,7,0, with one idle bubble between consecutive grants.
- Wrap-around: ptr=7 (after owner 6 releases), req=8'b1000_0001 → grant 7 first. After 7 releases, grant 0.
- Hold limit: MAX_HOLD=4, req=8'b0000_0011 held constantly → owner 0 for exactly 4 cycles, timeout pulse, bubble, owner 1 for 4 cycles, and so on. Repeat with req=8'b0000_0001 only → owner 0 is never preempted and timeout stays 0.
- Enable: enable=0 with req=8'hFF → no grant. Drop enable during a grant → gnt=0 next cycle and ptr advances. Re-raise enable → the next requester after the previous owner is granted.
